// File: rtl/traffic_cd_ctrl.sv
// Two-approach traffic light controller with a two-digit BCD countdown on a scanned 7-segment display.
// Optional pedestrian shortening of the green phase is enabled by defining TRAFFIC_PED_REQ_EN.
module traffic_cd_ctrl #(
   parameter int CLK_DIV  = 50000000,
   parameter int SCAN_DIV = 50000,
   parameter int GREEN_T  = 25,
   parameter int YELLOW_T = 3
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       ped_req,
   output logic [2:0] light_ns,
   output logic [2:0] light_ew,
   output logic [1:0] digit_sel,
   output logic [3:0] bcd_out
);

   localparam int PRE_W = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
   localparam int SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);
   localparam logic [SCN_W-1:0] SCAN_MAX = SCN_W'(SCAN_DIV - 1);
   localparam logic [3:0] G_TENS  = 4'(GREEN_T / 10);
   localparam logic [3:0] G_UNITS = 4'(GREEN_T % 10);
   localparam logic [3:0] Y_TENS  = 4'(YELLOW_T / 10);
   localparam logic [3:0] Y_UNITS = 4'(YELLOW_T % 10);

   typedef enum logic [1:0] {NS_G, NS_Y, EW_G, EW_Y} state_t;

   state_t           state, state_nx;
   logic [3:0]       tens, units, tens_nx, units_nx;
   logic [PRE_W-1:0] pre, pre_nx;
   logic [SCN_W-1:0] scan, scan_nx;
   logic [1:0]       sel_nx;
   logic [3:0]       bcd_nx;
   logic [2:0]       ns_nx, ew_nx;
   logic             tick, green, ped_pend;

`ifdef TRAFFIC_PED_REQ_EN
   logic ped_l, ped_l_nx;
   assign ped_pend = ped_l | ped_req;
`else
   logic unused_ped;
   assign unused_ped = ped_req;
   assign ped_pend   = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      tens_nx  = tens;
      units_nx = units;
      pre_nx   = pre;
      scan_nx  = scan + 1'b1;
      sel_nx   = digit_sel;
      ns_nx    = 3'b100;
      ew_nx    = 3'b100;

      tick  = en && (pre == PRE_MAX);
      green = (state == NS_G) || (state == EW_G);
      if (en)
         pre_nx = tick ? '0 : pre + 1'b1;

      // A pending pedestrian cut pre-empts the tick; the two never conflict since the cut needs cnt > 05.
      if (ped_pend && green && (tens != 4'd0 || units > 4'd5)) begin
         tens_nx  = 4'd0;
         units_nx = 4'd5;
      end else if (tick) begin
         if (tens == 4'd0 && units == 4'd1) begin
            unique case (state)
               NS_G: state_nx = NS_Y;
               NS_Y: state_nx = EW_G;
               EW_G: state_nx = EW_Y;
               EW_Y: state_nx = NS_G;
            endcase
            tens_nx  = green ? Y_TENS  : G_TENS;
            units_nx = green ? Y_UNITS : G_UNITS;
         end else if (units == 4'd0) begin
            units_nx = 4'd9;
            tens_nx  = tens - 4'd1;
         end else begin
            units_nx = units - 4'd1;
         end
      end

`ifdef TRAFFIC_PED_REQ_EN
      ped_l_nx = ped_req | (ped_l & ~(green && state_nx != state));
`endif

      if (scan == SCAN_MAX) begin
         scan_nx = '0;
         sel_nx  = ~digit_sel;
      end
      bcd_nx = (sel_nx == 2'b01) ? units_nx : tens_nx;

      unique case (state_nx)
         NS_G: ns_nx = 3'b001;
         NS_Y: ns_nx = 3'b010;
         EW_G: ew_nx = 3'b001;
         EW_Y: ew_nx = 3'b010;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= NS_G;
         tens      <= G_TENS;
         units     <= G_UNITS;
         pre       <= '0;
         scan      <= '0;
         digit_sel <= 2'b01;
         bcd_out   <= G_UNITS;
         light_ns  <= 3'b001;
         light_ew  <= 3'b100;
`ifdef TRAFFIC_PED_REQ_EN
         ped_l     <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         tens      <= tens_nx;
         units     <= units_nx;
         pre       <= pre_nx;
         scan      <= scan_nx;
         digit_sel <= sel_nx;
         bcd_out   <= bcd_nx;
         light_ns  <= ns_nx;
         light_ew  <= ew_nx;
`ifdef TRAFFIC_PED_REQ_EN
         ped_l     <= ped_l_nx;
`endif
      end
   end

endmodule
